hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Register-level hazard scheduler for the decode stage. It tracks, per architectural register, how many issued-but-not-written-back instructions target it. It holds the IF/ID pipeline frozen while a decoded instruction reads a pending register, or targets a register whose pending count is saturated. It sits beside the decode stage: it consumes decode-stage source/destination fields and the writeback port, and drives the decode `Freeze` input.

## Interface
Parameters:
- `REG_COUNT`, 16, number of architectural registers.
- `REG_FILE_DEPTH`, 4, register index width.
- `CNT_W`, 2, per-register pending counter width; max pending per register = 2^CNT_W-1 (3).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `id_valid`  in  1  decode stage holds a valid decoded instruction.
- `id_src1`  in  REG_FILE_DEPTH  first source register index.
- `id_has_src1`  in  1  first source is actually read.
- `id_src2`  in  REG_FILE_DEPTH  second source register index.
- `id_has_src2`  in  1  second source is actually read.
- `id_wb_en`  in  1  decoded instruction writes a register.
- `id_dst`  in  REG_FILE_DEPTH  destination register index.
- `flush`  in  1  branch taken; the current decode instruction is discarded.
- `wb_en`  in  1  writeback commits this cycle.
- `wb_dst`  in  REG_FILE_DEPTH  writeback register index.
- `freeze`  out  1  stall IF/ID; combinational.
- `issue`  out  1  decode instruction accepted into EX this cycle; combinational.
- `pending_mask`  out  REG_COUNT  bit r = count[r]!=0; registered.
- `wb_err`  out  1  sticky: writeback arrived for a register with count 0.

## Operation
- State is `count[r]` (CNT_W bits each) plus `wb_err`.
- `hazard = (id_has_src1 & count[id_src1]!=0) | (id_has_src2 & count[id_src2]!=0)`.
  - Only registered counts are used. A writeback in the same cycle does not clear the hazard.
- `sat = id_wb_en & count[id_dst]==max`.
- `freeze = id_valid & ~flush & (hazard | sat)`.
- `issue = id_valid & ~flush & ~hazard & ~sat`.
- `inc[r] = issue & id_wb_en & id_dst==r`.
- `dec[r] = wb_en & wb_dst==r & count[r]!=0`.
- Counter update: `count[r]` next = count + inc − dec.
  - Simultaneous inc and dec on the same r: unchanged.
  - Counts never wrap: saturation blocks inc, and the zero check blocks dec.
- `wb_en` with `count[wb_dst]==0`: no count change; `wb_err` set to 1 and held until `rst`.
- `flush`: suppresses issue and freeze for that cycle only. It does not alter counts, because instructions already past decode still write back.
- An instruction with no sources and `id_wb_en=0` always issues when valid and not flushed.
- An instruction with `id_src == id_dst` and a nonzero count stalls (RAW takes precedence).

## Timing
- Reset: all `count`=0, `pending_mask`=0, `wb_err`=0.
  - `freeze` and `issue` are 0 whenever `id_valid`=0.
  - With reset asserted, `freeze` and `issue` are driven 0 regardless of inputs.
- `rst` asserted mid-operation: the next edge clears all counts. In-flight writebacks that arrive after reset are reported through `wb_err`.
- Issue in cycle N sets the `pending_mask` bit at edge N+1. A dependent instruction in decode at N+1 sees `freeze`=1.
- Writeback in cycle N decrements at edge N+1. The dependent instruction issues in cycle N+1, and the register file holds the written value by then.
- `freeze` and `issue` have zero latency (combinational from inputs and registered counts). No combinational path exists from `wb_en` to `freeze`.

## Structure
- `REG_COUNT` and `REG_FILE_DEPTH` come from the shared `constants.h`.
- Add `SCOREBOARD_CNT_W` to `constants.h`.
- One sub-module, `scoreboard_counter`: CNT_W up/down counter with `inc`, `dec`, synchronous `rst`, and `nonzero`/`full` flags. Instantiate it REG_COUNT times in a generate loop.
- Index decode, hazard logic and `wb_err` live in the top module.

## Test plan
- Reset, then `id_valid`=1, dst=R3, `id_wb_en`=1, no sources → `issue`=1; next cycle `pending_mask`=0x0008.
- Then decode reads src1=R3 → `freeze`=1 each cycle. Pulse `wb_en`, `wb_dst`=3 at cycle N → `freeze` stays 1 in N; `issue`=1 and `pending_mask`=0 at N+1.
- Issue three writes to R5 back-to-back → count 3. The fourth write to R5 (no sources) → `freeze`=1 until one `wb_en`, `wb_dst`=5.
- Same cycle: issue to R7 while `wb_en`, `wb_dst`=7 with count 1 → count stays 1 and `pending_mask[7]`=1.
- `wb_en`, `wb_dst`=9 with count 0 → `wb_err`=1 and held; `pending_mask` unchanged. Then `rst` → `wb_err`=0.
- Hazard on R2 with `flush`=1 → `freeze`=0, `issue`=0, counts unchanged. Assert `rst` with counts nonzero → `pending_mask`=0 after one edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and decode-request payload for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_COUNT        = 16;
  localparam int unsigned REG_FILE_DEPTH   = 4;
  localparam int unsigned SCOREBOARD_CNT_W = 2;

  // Decoded-instruction fields presented by the decode stage in one cycle.
  typedef struct packed {
    logic                      valid;
    logic [REG_FILE_DEPTH-1:0] src1;
    logic                      has_src1;
    logic [REG_FILE_DEPTH-1:0] src2;
    logic                      has_src2;
    logic                      wb_en;
    logic [REG_FILE_DEPTH-1:0] dst;
  } id_req_t;

endpackage

// File: rtl/scoreboard_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module scoreboard_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SCOREBOARD_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             up;
  logic             down;

  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == CNT_MAX);

  // Never wrap: increments stop at max, decrements stop at zero; a matched pair cancels.
  always_comb begin
    up    = inc & ~full;
    down  = dec & nonzero;
    cnt_d = cnt_q;
    if (up && !down) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (down && !up) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending-write counts drive
// the IF/ID freeze and the issue handshake; writebacks retire pending writes.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_COUNT      = hazard_scoreboard_pkg::REG_COUNT,
  parameter int unsigned REG_FILE_DEPTH = hazard_scoreboard_pkg::REG_FILE_DEPTH,
  parameter int unsigned CNT_W          = SCOREBOARD_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_FILE_DEPTH-1:0] id_src1,
  input  logic                      id_has_src1,
  input  logic [REG_FILE_DEPTH-1:0] id_src2,
  input  logic                      id_has_src2,
  input  logic                      id_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] id_dst,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [REG_FILE_DEPTH-1:0] wb_dst,
  output logic                      freeze,
  output logic                      issue,
  output logic [REG_COUNT-1:0]      pending_mask,
  output logic                      wb_err
);

  id_req_t              id_req;
  logic [REG_COUNT-1:0] nonzero;
  logic [REG_COUNT-1:0] full;
  logic [REG_COUNT-1:0] inc;
  logic [REG_COUNT-1:0] dec;
  logic                 hazard;
  logic                 sat;
  logic                 live;
  logic                 wb_err_q;
  logic                 wb_err_d;

  always_comb begin
    id_req          = '0;
    id_req.valid    = id_valid;
    id_req.src1     = id_src1;
    id_req.has_src1 = id_has_src1;
    id_req.src2     = id_src2;
    id_req.has_src2 = id_has_src2;
    id_req.wb_en    = id_wb_en;
    id_req.dst      = id_dst;
  end

  // Hazard check uses only registered counts, so writeback never reaches freeze combinationally.
  always_comb begin
    hazard = (id_req.has_src1 & nonzero[id_req.src1])
           | (id_req.has_src2 & nonzero[id_req.src2]);
    sat    = id_req.wb_en & full[id_req.dst];
    live   = ~rst & id_req.valid & ~flush;
    freeze = live & (hazard | sat);
    issue  = live & ~hazard & ~sat;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 0; r < REG_COUNT; r++) begin
      inc[r] = issue & id_req.wb_en & (id_req.dst == REG_FILE_DEPTH'(r));
      dec[r] = wb_en & (wb_dst == REG_FILE_DEPTH'(r)) & nonzero[r];
    end
  end

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_cnt
    scoreboard_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[r]),
      .dec     (dec[r]),
      .nonzero (nonzero[r]),
      .full    (full[r])
    );
  end

  // A writeback with nothing pending is a protocol error, held until reset.
  always_comb begin
    wb_err_d = wb_err_q | (wb_en & ~nonzero[wb_dst]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign pending_mask = nonzero;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic,
// checked against a per-register pending-count model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic        id_has_src1;
  logic [3:0]  id_src2;
  logic        id_has_src2;
  logic        id_wb_en;
  logic [3:0]  id_dst;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_dst;
  logic        freeze;
  logic        issue;
  logic [15:0] pending_mask;
  logic        wb_err;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_has_src1  (id_has_src1),
    .id_src2      (id_src2),
    .id_has_src2  (id_has_src2),
    .id_wb_en     (id_wb_en),
    .id_dst       (id_dst),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_dst       (wb_dst),
    .freeze       (freeze),
    .issue        (issue),
    .pending_mask (pending_mask),
    .wb_err       (wb_err)
  );

  typedef struct {
    bit        fr;
    bit        is;
    bit [15:0] pm;
    bit        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: number of outstanding writes per register, and the error flag.
  int cnt[16];
  bit m_err;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Drive one decode/writeback cycle, predict its outputs, then advance the model.
  task automatic drive(input bit r, input bit v,
                       input bit [3:0] s1, input bit h1,
                       input bit [3:0] s2, input bit h2,
                       input bit we, input bit [3:0] d,
                       input bit fl, input bit wbe, input bit [3:0] wd);
    exp_t e;
    int   old[16];
    bit   haz, sat;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_src1 = s1; id_has_src1 = h1; id_src2 = s2;
    id_has_src2 = h2; id_wb_en = we; id_dst = d; flush = fl; wb_en = wbe; wb_dst = wd;
    e.pm = '0;
    for (int i = 0; i < 16; i++) if (cnt[i] > 0) e.pm[i] = 1'b1;
    e.err = m_err;
    haz = (h1 && cnt[s1] > 0) || (h2 && cnt[s2] > 0);
    sat = we && cnt[d] == 3;
    e.fr = !r && v && !fl && (haz || sat);
    e.is = !r && v && !fl && !haz && !sat;
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      m_err = 1'b0;
    end else begin
      old = cnt;
      if (e.is && we) cnt[d] = cnt[d] + 1;
      if (wbe) begin
        if (old[wd] == 0) m_err = 1'b1;
        else cnt[wd] = cnt[wd] - 1;
      end
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("freeze", int'(freeze), int'(e.fr));
        check("issue", int'(issue), int'(e.is));
        check("pending_mask", int'(pending_mask), int'(e.pm));
        check("wb_err", int'(wb_err), int'(e.err));
      end
    end
  end

  initial begin
    bit [3:0] wd;
    int       pend[$];
    rst = 1'b1; id_valid = 0; id_src1 = 0; id_has_src1 = 0; id_src2 = 0; id_has_src2 = 0;
    id_wb_en = 0; id_dst = 0; flush = 0; wb_en = 0; wb_dst = 0;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    m_err = 1'b0;

    drive(1, 1, 3, 1, 0, 0, 1, 3, 0, 1, 3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write R3, then a reader of R3 stalls until writeback retires it.
    drive(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    repeat (3) drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 3);
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);

    // Saturate R5, a fourth writer stalls until one retires.
    repeat (3) drive(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 5, 0, 1, 5);
    drive(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);

    // Issue and writeback on R7 in the same cycle keep the count at one.
    drive(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7);
    idle();

    // Spurious writeback raises a sticky error; reset clears everything.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    repeat (2) idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Flush masks a hazard on R2; reset with pending counts clears the mask.
    drive(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    drive(0, 1, 2, 1, 2, 1, 1, 4, 1, 0, 0);
    drive(0, 1, 4, 0, 2, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    drive(0, 1, 2, 1, 0, 0, 1, 2, 0, 0, 0);

    // Random traffic on a narrow register window to provoke hazards and saturation.
    for (int n = 0; n < 2000; n++) begin
      pend.delete();
      for (int i = 0; i < 16; i++) if (cnt[i] > 0) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 9) < 8)
        wd = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wd = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
            4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, wd);
    end
    idle();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
